// File: rtl/onchip_word_prefetcher_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | onchip_word_prefetcher_pkg : shared Avalon constants, FSM states, widths  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package onchip_word_prefetcher_pkg;

   localparam logic         AVM_WRITE_VAL = 1'b0;
   localparam logic         AVM_CLKEN_VAL = 1'b1;
   localparam logic [127:0] AVM_BE_ALL    = '1;

   localparam int PF_FIFO_DEPTH = 4;
   localparam int PF_CNT_W      = $clog2(PF_FIFO_DEPTH + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DRAIN = 2'd2
   } state_e;

   // Counter wide enough to hold 0..depth inclusive.
   function automatic int cnt_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/onchip_word_prefetcher_sync_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sync_fifo : single-clock FIFO with registered count/full/empty flags       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module sync_fifo
   import onchip_word_prefetcher_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int FIFO_DEPTH = PF_FIFO_DEPTH
) (
   input  logic                                 clk,
   input  logic                                 reset_n,
   input  logic                                 push,
   input  logic [DATA_W-1:0]                    din,
   input  logic                                 pop,
   output logic [DATA_W-1:0]                    dout,
   output logic                                 full,
   output logic                                 empty,
   output logic [cnt_width(FIFO_DEPTH)-1:0]     count
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = cnt_width(FIFO_DEPTH);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

   logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
   logic [DATA_W-1:0] mem_d [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              full_q, full_d, empty_q, empty_d;
   logic              do_push, do_pop;

   assign do_push = push & ~full_q;
   assign do_pop  = pop & ~empty_q;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = din;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
      empty_d = (count_d == '0);
      full_d  = (count_d == FULL_CNT);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         full_q   <= full_d;
         empty_q  <= empty_d;
      end
   end

   assign dout  = mem_q[rd_ptr_q];
   assign full  = full_q;
   assign empty = empty_q;
   assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/onchip_word_prefetcher.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | onchip_word_prefetcher : credit-limited Avalon-MM read master to stream   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module onchip_word_prefetcher
   import onchip_word_prefetcher_pkg::*;
#(
   parameter int ADDR_W       = 2,
   parameter int DATA_W       = 32,
   parameter int FIFO_DEPTH   = PF_FIFO_DEPTH,
   parameter int READ_LATENCY = 1
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                start,
   input  logic [ADDR_W-1:0]   base_addr,
   input  logic [ADDR_W:0]     word_count,
   output logic                busy,
   output logic                done,
   output logic [ADDR_W-1:0]   m_address,
   output logic                m_chipselect,
   output logic                m_write,
   output logic [DATA_W/8-1:0] m_byteenable,
   output logic                m_clken,
   input  logic [DATA_W-1:0]   m_readdata,
   output logic [DATA_W-1:0]   out_data,
   output logic                out_valid,
   input  logic                out_ready
);

   localparam int CNT_W = cnt_width(FIFO_DEPTH);
   localparam logic [CNT_W:0] CREDITS = (CNT_W + 1)'(FIFO_DEPTH);

   state_e                  state_q, state_d;
   logic [ADDR_W-1:0]       addr_q, addr_d;
   logic [ADDR_W:0]         rem_q, rem_d;
   logic                    busy_q, busy_d, done_q, done_d;
   logic [READ_LATENCY-1:0] vld_q, vld_d;
   logic [CNT_W-1:0]        inflight, fifo_count;
   logic                    fifo_full, fifo_empty, fifo_push, fifo_pop;
   logic                    issue, drain_exit;

   always_comb begin
      inflight = '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
         inflight = inflight + CNT_W'(vld_q[i]);
      end
   end

   // Credits count only registered occupancy, so a word issued this cycle is
   // already covered by the check that allowed it.
   assign issue = (state_q == FETCH) && (rem_q != '0) &&
                  (({1'b0, fifo_count} + {1'b0, inflight}) < CREDITS);

   assign fifo_push = vld_q[READ_LATENCY-1] & ~fifo_full;
   assign fifo_pop  = ~fifo_empty & out_ready;

   assign drain_exit = (state_q == DRAIN) && (inflight == '0) &&
                       (fifo_empty || ((fifo_count == CNT_W'(1)) && fifo_pop));

   always_comb begin
      vld_d[0] = issue;
      for (int i = 1; i < READ_LATENCY; i++) begin
         vld_d[i] = vld_q[i-1];
      end
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      rem_d   = rem_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               if (word_count != '0) begin
                  state_d = FETCH;
                  addr_d  = base_addr;
                  rem_d   = word_count;
                  busy_d  = 1'b1;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         FETCH: begin
            if (issue) begin
               addr_d = addr_q + ADDR_W'(1);
               rem_d  = rem_q - (ADDR_W + 1)'(1);
               if (rem_q == (ADDR_W + 1)'(1)) begin
                  state_d = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (drain_exit) begin
               state_d = IDLE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         addr_q  <= '0;
         rem_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         vld_q   <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         rem_q   <= rem_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         vld_q   <= vld_d;
      end
   end

   sync_fifo #(
      .DATA_W     (DATA_W),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (fifo_push),
      .din     (m_readdata),
      .pop     (fifo_pop),
      .dout    (out_data),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   assign busy         = busy_q;
   assign done         = done_q;
   assign m_address    = addr_q;
   assign m_chipselect = issue;
   assign m_write      = AVM_WRITE_VAL;
   assign m_byteenable = AVM_BE_ALL[DATA_W/8-1:0];
   assign m_clken      = AVM_CLKEN_VAL;
   assign out_valid    = ~fifo_empty;

endmodule
`default_nettype wire

// File: tb/tb_onchip_word_prefetcher.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_onchip_word_prefetcher : directed + random runs against a queue model  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_onchip_word_prefetcher;

   localparam int ADDR_W       = 2;
   localparam int DATA_W       = 32;
   localparam int FIFO_DEPTH   = 4;
   localparam int READ_LATENCY = 1;
   localparam int DEPTH        = 1 << ADDR_W;

   logic                clk = 1'b0;
   logic                reset_n = 1'b1;
   logic                start = 1'b0;
   logic [ADDR_W-1:0]   base_addr = '0;
   logic [ADDR_W:0]     word_count = '0;
   logic                busy, done;
   logic [ADDR_W-1:0]   m_address;
   logic                m_chipselect, m_write, m_clken;
   logic [DATA_W/8-1:0] m_byteenable;
   logic [DATA_W-1:0]   m_readdata;
   logic [DATA_W-1:0]   out_data;
   logic                out_valid;
   logic                out_ready = 1'b0;

   logic [DATA_W-1:0] mem [DEPTH];

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   onchip_word_prefetcher #(
      .ADDR_W       (ADDR_W),
      .DATA_W       (DATA_W),
      .FIFO_DEPTH   (FIFO_DEPTH),
      .READ_LATENCY (READ_LATENCY)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .start        (start),
      .base_addr    (base_addr),
      .word_count   (word_count),
      .busy         (busy),
      .done         (done),
      .m_address    (m_address),
      .m_chipselect (m_chipselect),
      .m_write      (m_write),
      .m_byteenable (m_byteenable),
      .m_clken      (m_clken),
      .m_readdata   (m_readdata),
      .out_data     (out_data),
      .out_valid    (out_valid),
      .out_ready    (out_ready)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // On-chip memory slave: one-cycle registered read.
   always @(posedge clk) begin
      if (m_chipselect && !m_write) m_readdata <= mem[m_address];
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Bus/stream observations for the current run.
   int                cs_cyc[$];
   logic [ADDR_W-1:0] cs_addr[$];
   int                pop_cyc[$];
   logic [DATA_W-1:0] pop_data[$];
   int                done_cyc[$];
   int                busy_cycles = 0;
   int                issued = 0;
   int                popped = 0;
   bit                prev_stall = 1'b0;
   logic [DATA_W-1:0] prev_data = '0;

   always @(negedge clk) begin
      if (!reset_n) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            chk("stall_valid", out_valid, 1);
            chk("stall_data", out_data, prev_data);
         end
         if (m_chipselect) begin
            cs_cyc.push_back(cyc);
            cs_addr.push_back(m_address);
            issued++;
            chk("outstanding_le_depth", (issued - popped) <= FIFO_DEPTH, 1);
         end
         if (out_valid && out_ready) begin
            pop_cyc.push_back(cyc);
            pop_data.push_back(out_data);
            popped++;
         end
         if (done) done_cyc.push_back(cyc);
         if (busy) busy_cycles++;
         prev_stall = out_valid && !out_ready;
         prev_data  = out_data;
      end
   end

   function automatic logic ready_for(input int mode, input int k);
      case (mode)
         0:       return 1'b1;
         1:       return (k >= 10);
         2:       return k[0];
         default: return 1'($urandom_range(0, 1));
      endcase
   endfunction

   task automatic clear_obs();
      cs_cyc.delete();
      cs_addr.delete();
      pop_cyc.delete();
      pop_data.delete();
      done_cyc.delete();
      busy_cycles = 0;
      issued      = 0;
      popped      = 0;
   endtask

   // mode: 0 ready high, 1 ready low for 10 cycles, 2 toggling, 3 random.
   task automatic run(input int b, input int n, input int mode);
      logic [DATA_W-1:0] exp_q[$];
      int c0, rel;
      bit fin;
      for (int i = 0; i < n; i++) exp_q.push_back(mem[(b + i) % DEPTH]);
      @(posedge clk); #1;
      clear_obs();
      start      = 1'b1;
      base_addr  = ADDR_W'(b);
      word_count = (ADDR_W + 1)'(n);
      out_ready  = ready_for(mode, 0);
      c0         = cyc;
      fin        = 1'b0;
      for (int k = 1; k < 200 && !fin; k++) begin
         @(posedge clk); #1;
         // Starts while busy must be ignored, whatever their parameters.
         start      = busy ? 1'($urandom_range(0, 1)) : 1'b0;
         base_addr  = ADDR_W'($urandom);
         word_count = (ADDR_W + 1)'($urandom);
         out_ready  = ready_for(mode, k);
         if (done_cyc.size() > 0 && (cyc - done_cyc[0]) >= 2) fin = 1'b1;
      end
      start = 1'b0;
      chk("run_finished_in_budget", fin, 1);
      chk("cs_count", cs_cyc.size(), n);
      for (int i = 0; i < n && i < cs_addr.size(); i++)
         chk("cs_addr", cs_addr[i], (b + i) % DEPTH);
      chk("word_count_out", pop_data.size(), n);
      for (int i = 0; i < n && i < pop_data.size(); i++)
         chk("word_data", pop_data[i], exp_q[i]);
      chk("done_pulses", done_cyc.size(), 1);
      if (done_cyc.size() > 0) begin
         rel = done_cyc[0] - c0;
         if (n == 0) begin
            chk("done_cycle_zero_count", rel, 1);
            chk("busy_cycles_zero_count", busy_cycles, 0);
         end else begin
            chk("busy_span", busy_cycles, rel - 1);
            if (pop_cyc.size() > 0)
               chk("done_after_last_pop", rel, pop_cyc[pop_cyc.size()-1] - c0 + 1);
            if (mode == 0) begin
               chk("done_cycle", rel, n + 3);
               for (int i = 0; i < cs_cyc.size(); i++) chk("cs_cycle", cs_cyc[i] - c0, i + 1);
               for (int i = 0; i < pop_cyc.size(); i++) chk("pop_cycle", pop_cyc[i] - c0, i + 3);
            end
         end
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_cs"}, m_chipselect, 0);
      chk({tag, "_addr"}, m_address, 0);
      chk({tag, "_valid"}, out_valid, 0);
      chk({tag, "_data"}, out_data, 0);
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) mem[i] = DATA_W'(32'hA0 + i);

      #2 reset_n = 1'b0;
      #1;
      chk_reset_outputs("reset");
      chk("m_write", m_write, 0);
      chk("m_byteenable", m_byteenable, {(DATA_W/8){1'b1}});
      chk("m_clken", m_clken, 1);
      repeat (2) @(posedge clk);
      @(negedge clk) reset_n = 1'b1;

      run(0, 4, 0);
      run(3, 3, 0);
      run(0, 4, 1);
      run(0, 4, 2);
      run(1, 0, 0);

      // Reset in the middle of a fetch, with the stream stalled.
      @(posedge clk); #1;
      clear_obs();
      start      = 1'b1;
      base_addr  = ADDR_W'(1);
      word_count = (ADDR_W + 1)'(4);
      out_ready  = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      for (int k = 0; k < 20 && issued < 2; k++) @(posedge clk);
      chk("midfetch_two_issues", issued >= 2, 1);
      #3 reset_n = 1'b0;
      #1;
      chk_reset_outputs("midfetch_reset");
      repeat (2) @(posedge clk);
      #1;
      chk_reset_outputs("held_reset");
      @(negedge clk) reset_n = 1'b1;
      run(2, 3, 0);

      for (int r = 0; r < 12; r++) begin
         for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
         run($urandom_range(0, DEPTH - 1), $urandom_range(0, DEPTH), $urandom_range(0, 3));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
